dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the processor's single-port data memory between two requesters: the processor's LW/SW path (cpu) and an external loader/debug port (ext).
- Sits between the processor datapath and the data memory macro.
- Grants at most one access per cycle and returns read data one cycle after a read grant.
- Stalls the processor while its access is denied.
- Bounds ext lock bursts so the cpu cannot starve.

Parameters:
- ADDR_W, 8, data memory address width.
- DATA_W, 16, data word width.
- MAX_LOCK, 4, maximum consecutive ext grants under ext_lock before cpu is forced.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  cpu access request; held with fields stable until cpu_gnt.
- cpu_we  in  1  1 = write (SW), 0 = read (LW).
- cpu_addr  in  ADDR_W  cpu address.
- cpu_wdata  in  DATA_W  cpu write data.
- cpu_gnt  out  1  cpu access accepted this cycle (combinational).
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes PC/pipeline.
- cpu_rdata  out  DATA_W  read data for cpu.
- cpu_rvalid  out  1  cpu_rdata valid (1 cycle after a cpu read grant).
- ext_req  in  1  ext access request; same hold rule as cpu.
- ext_we  in  1  ext write enable.
- ext_lock  in  1  ext requests continued priority (burst).
- ext_addr  in  ADDR_W  ext address.
- ext_wdata  in  DATA_W  ext write data.
- ext_gnt  out  1  ext access accepted this cycle.
- ext_rdata  out  DATA_W  read data for ext.
- ext_rvalid  out  1  ext_rdata valid.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en & ~mem_we.

Behaviour:
- Grant is combinational from requests and registered priority state. cpu_gnt and ext_gnt are never both 1.
- Only one requesting: that requester is granted.
- Both requesting: the requester not granted most recently wins (round-robin via last_owner register).
- Lock override: if lock_active and lock_cnt < MAX_LOCK, ext wins regardless of last_owner.
- Lock forcing: when lock_cnt reaches MAX_LOCK with cpu_req=1, cpu wins; lock_cnt clears on that cpu grant.
- Lock state machine: states NORMAL and LOCKED.
  - NORMAL -> LOCKED when ext is granted with ext_lock=1; lock_cnt=1.
  - LOCKED: each ext grant increments lock_cnt, saturating at MAX_LOCK.
  - LOCKED -> NORMAL when ext_lock=0 at an ext grant, when ext_req drops, or when cpu is granted.
- last_owner updates on every grant. No grant leaves it unchanged.
- mem_* mux: granted requester's fields drive mem_addr/mem_wdata/mem_we; mem_en = cpu_gnt | ext_gnt.
  - No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - rd_owner register captures the owner of a read grant; it is empty for writes.
  - Next cycle, the matching rvalid=1 and its rdata=mem_rdata; the other rvalid=0.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating owners each return in order, one cycle apart.
- cpu_stall is combinational; 1 for every cycle cpu_req=1 without grant.
- rdata outputs hold their last value when rvalid=0 (0 after reset).
- Reset (synchronous):
  - last_owner=ext, so cpu wins the first tie.
  - State NORMAL, lock_cnt=0, rd_owner=none.
  - All rvalid=0 and rdata=0. gnt/mem_en are still combinational; with no requests, all outputs are 0.
  - A read granted in the cycle rst is asserted produces no rvalid afterwards. Outstanding reads are discarded on reset.
- Widths:
  - lock_cnt is clog2(MAX_LOCK+1) bits and saturating.
  - No arithmetic on data. Addresses pass through unmodified.

Decomposition:
- Shared package dmem_pkg:
  - owner_e {OWN_NONE, OWN_CPU, OWN_EXT}.
  - lock_state_e {NORMAL, LOCKED}.
  - Default ADDR_W/DATA_W constants.
- One natural sub-module, rr_lock_arbiter: two-requester grant logic plus last_owner/lock FSM/lock_cnt.
- The top level holds the mem mux and the read-return register.

Test Plan:
- Reset, then cpu read addr 0x10 alone; memory holds 0x1234 -> cpu_gnt=1 same cycle, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0x1234, ext_rvalid=0.
- First cycle after reset, cpu and ext both request (cpu read 0x01, ext write 0x02=0xBEEF) -> cpu granted cycle 1, ext cycle 2; cpu_stall=0 both cycles; mem[0x02]=0xBEEF afterwards.
- Sustained cpu and ext requests, no lock, 6 cycles -> grants alternate cpu, ext, cpu, ext, cpu, ext; cpu_stall=1 on ext cycles.
- ext_lock=1 with continuous ext and cpu requests, MAX_LOCK=4 -> after first ext grant, ext granted 4 consecutive cycles, then cpu granted; lock_cnt back to 0 and state NORMAL.
- ext read 0x20 then cpu read 0x21 on consecutive cycles (mem 0xAAAA/0x5555) -> ext_rvalid with 0xAAAA, then cpu_rvalid with 0x5555, never both in the same cycle.
- cpu read granted, rst asserted on the next edge -> no cpu_rvalid afterwards; all outputs 0 with no requests; first tie after reset goes to cpu.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory arbiter slice.
package dmem_pkg;

  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned MAX_LOCK_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_EXT
  } owner_e;

  typedef enum logic {
    NORMAL,
    LOCKED
  } lock_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_lock_arbiter.sv
// Two-requester round-robin arbiter with a bounded ext lock burst.
module rr_lock_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic ext_req,
  input  logic ext_lock,
  output logic cpu_gnt,
  output logic ext_gnt
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  lock_state_e      state, state_next;
  logic [CNT_W-1:0] lock_cnt, cnt_next;
  owner_e           last_owner;

  // Lock priority only matters on a tie; a lone requester always wins.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (cpu_req && ext_req) begin
      if (state == LOCKED) begin
        if (lock_cnt < CNT_MAX) ext_gnt = 1'b1;
        else                    cpu_gnt = 1'b1;
      end else if (last_owner == OWN_CPU) begin
        ext_gnt = 1'b1;
      end else begin
        cpu_gnt = 1'b1;
      end
    end else begin
      cpu_gnt = cpu_req;
      ext_gnt = ext_req;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = lock_cnt;
    case (state)
      NORMAL: begin
        if (ext_gnt && ext_lock) begin
          state_next = LOCKED;
          cnt_next   = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (cpu_gnt || !ext_req || (ext_gnt && !ext_lock)) begin
          state_next = NORMAL;
          cnt_next   = '0;
        end else if (ext_gnt && (lock_cnt < CNT_MAX)) begin
          cnt_next = lock_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = NORMAL;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= NORMAL;
      lock_cnt   <= '0;
      last_owner <= OWN_EXT;
    end else begin
      state    <= state_next;
      lock_cnt <= cnt_next;
      if (cpu_gnt)      last_owner <= OWN_CPU;
      else if (ext_gnt) last_owner <= OWN_EXT;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the cpu LW/SW path and an ext port.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e           rd_owner;
  logic [DATA_W-1:0] cpu_rdata_q, ext_rdata_q;

  rr_lock_arbiter #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .ext_req  (ext_req),
    .ext_lock (ext_lock),
    .cpu_gnt  (cpu_gnt),
    .ext_gnt  (ext_gnt)
  );

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner <= OWN_NONE;
    end else if (cpu_gnt && !cpu_we) begin
      rd_owner <= OWN_CPU;
    end else if (ext_gnt && !ext_we) begin
      rd_owner <= OWN_EXT;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign ext_rvalid = (rd_owner == OWN_EXT);

  // Return data passes straight through in the valid cycle and is held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (ext_rvalid) ext_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ext_rdata = ext_rvalid ? mem_rdata : ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [7:0]  cpu_addr, ext_addr, mem_addr;
  logic [15:0] cpu_wdata, ext_wdata, mem_wdata, mem_rdata;
  logic [15:0] cpu_rdata, ext_rdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_en, mem_we;

  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem_model [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_en) mem_model[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  task automatic idle;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk); pre_en = 1; pre_addr = a; pre_data = d;
    @(negedge clk); pre_en = 0;
  endtask

  task automatic do_reset;
    @(negedge clk); rst = 1; idle();
    @(negedge clk);
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    n_tests++;
    if ({cpu_gnt, ext_gnt, cpu_stall, cpu_rvalid, ext_rvalid, mem_en, mem_we} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: gnt/stall/rvalid/en/we=%b want 0000000",
               {cpu_gnt, ext_gnt, cpu_stall, cpu_rvalid, ext_rvalid, mem_en, mem_we});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, cpu_rdata, ext_rdata} !== 56'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h cpu_rdata=%h ext_rdata=%h want all 0",
               mem_addr, mem_wdata, cpu_rdata, ext_rdata);
    end
  endtask

  task automatic test_cpu_read;
    @(negedge clk); cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    #1;
    n_tests++;
    if ({cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we} !== 5'b10010 || mem_addr !== 8'h10) begin
      n_fail++;
      $display("FAIL cpu_rd_gnt: gnt/egnt/stall/en/we=%b addr=%h want 10010 addr 10",
               {cpu_gnt, ext_gnt, cpu_stall, mem_en, mem_we}, mem_addr);
    end
    @(negedge clk); cpu_req = 0;
    #1;
    n_tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234 || ext_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_rd_ret: rvalid=%b rdata=%h ext_rvalid=%b want 1 1234 0",
               cpu_rvalid, cpu_rdata, ext_rvalid);
    end
    @(negedge clk); #1;
    n_tests++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL cpu_rd_hold: rvalid=%b rdata=%h want 0 1234", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_first_tie;
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
    ext_req = 1; ext_we = 1; ext_addr = 8'h02; ext_wdata = 16'hBEEF;
    #1;
    n_tests++;
    if ({cpu_gnt, ext_gnt, cpu_stall} !== 3'b100) begin
      n_fail++;
      $display("FAIL tie_c1: cpu_gnt/ext_gnt/stall=%b want 100", {cpu_gnt, ext_gnt, cpu_stall});
    end
    @(negedge clk); cpu_req = 0;
    #1;
    n_tests++;
    if ({cpu_gnt, ext_gnt, cpu_stall, mem_we} !== 4'b0101 || mem_addr !== 8'h02 ||
        mem_wdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL tie_c2: cpu_gnt/ext_gnt/stall/we=%b addr=%h wdata=%h want 0101 02 BEEF",
               {cpu_gnt, ext_gnt, cpu_stall, mem_we}, mem_addr, mem_wdata);
    end
    n_tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h0C0C) begin
      n_fail++;
      $display("FAIL tie_rd: cpu_rvalid=%b rdata=%h want 1 0C0C", cpu_rvalid, cpu_rdata);
    end
    @(negedge clk); idle();
    #1;
    n_tests++;
    if (mem_model[8'h02] !== 16'hBEEF || ext_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_wr: mem[02]=%h ext_rvalid=%b want BEEF 0", mem_model[8'h02], ext_rvalid);
    end
  endtask

  task automatic test_round_robin;
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 16'h1111;
    ext_req = 1; ext_we = 1; ext_addr = 8'h41; ext_wdata = 16'h2222;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      n_tests++;
      if (cpu_gnt !== (i % 2 == 0) || ext_gnt !== (i % 2 == 1) || cpu_stall !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: cpu_gnt=%b ext_gnt=%b stall=%b want %b %b %b", i,
                 cpu_gnt, ext_gnt, cpu_stall, (i % 2 == 0), (i % 2 == 1), (i % 2 == 1));
      end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_lock;
    logic [6:0] exp_cpu;
    exp_cpu = 7'b0100001;
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 16'h3333;
    ext_req = 1; ext_we = 1; ext_lock = 1; ext_addr = 8'h31; ext_wdata = 16'h4444;
    for (int i = 0; i < 7; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      n_tests++;
      if (cpu_gnt !== exp_cpu[i] || ext_gnt !== !exp_cpu[i] || cpu_stall !== !exp_cpu[i]) begin
        n_fail++;
        $display("FAIL lock_cycle%0d: cpu_gnt=%b ext_gnt=%b stall=%b want %b %b %b", i,
                 cpu_gnt, ext_gnt, cpu_stall, exp_cpu[i], !exp_cpu[i], !exp_cpu[i]);
      end
      if (i == 4) begin
        n_tests++;
        if (dut.u_arb.lock_cnt !== 3'd3 || dut.u_arb.state !== LOCKED) begin
          n_fail++;
          $display("FAIL lock_mid: lock_cnt=%0d state=%0d want 3 LOCKED",
                   dut.u_arb.lock_cnt, dut.u_arb.state);
        end
      end
      if (i == 6) begin
        n_tests++;
        if (dut.u_arb.lock_cnt !== 3'd0 || dut.u_arb.state !== NORMAL) begin
          n_fail++;
          $display("FAIL lock_release: lock_cnt=%0d state=%0d want 0 NORMAL",
                   dut.u_arb.lock_cnt, dut.u_arb.state);
        end
      end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_back_to_back;
    @(negedge clk); ext_req = 1; ext_we = 0; ext_addr = 8'h20;
    @(negedge clk); idle(); cpu_req = 1; cpu_we = 0; cpu_addr = 8'h21;
    #1;
    n_tests++;
    if (ext_rvalid !== 1'b1 || ext_rdata !== 16'hAAAA || cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ext: ext_rvalid=%b ext_rdata=%h cpu_rvalid=%b cpu_gnt=%b want 1 AAAA 0 1",
               ext_rvalid, ext_rdata, cpu_rvalid, cpu_gnt);
    end
    @(negedge clk); idle();
    #1;
    n_tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h5555 || ext_rvalid !== 1'b0 || ext_rdata !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL b2b_cpu: cpu_rvalid=%b cpu_rdata=%h ext_rvalid=%b ext_rdata=%h want 1 5555 0 AAAA",
               cpu_rvalid, cpu_rdata, ext_rvalid, ext_rdata);
    end
    @(negedge clk); #1;
    n_tests++;
    if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: cpu_rvalid=%b ext_rvalid=%b want 0 0", cpu_rvalid, ext_rvalid);
    end
  endtask

  task automatic test_reset_discard;
    @(negedge clk); rst = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    #1;
    n_tests++;
    if (cpu_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_gnt: cpu_gnt=%b want 1", cpu_gnt);
    end
    @(negedge clk); rst = 0; idle();
    #1;
    n_tests++;
    if ({cpu_gnt, ext_gnt, cpu_stall, cpu_rvalid, ext_rvalid, mem_en} !== 6'b0 ||
        cpu_rdata !== 16'h0 || ext_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_discard: flags=%b cpu_rdata=%h ext_rdata=%h want 000000 0 0",
               {cpu_gnt, ext_gnt, cpu_stall, cpu_rvalid, ext_rvalid, mem_en}, cpu_rdata, ext_rdata);
    end
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h50;
    ext_req = 1; ext_we = 1; ext_addr = 8'h51;
    #1;
    n_tests++;
    if ({cpu_gnt, ext_gnt, cpu_stall} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_tie: cpu_gnt/ext_gnt/stall=%b want 100", {cpu_gnt, ext_gnt, cpu_stall});
    end
    @(negedge clk); idle();
  endtask

  initial begin
    rst = 1; pre_en = 0; pre_addr = '0; pre_data = '0; idle();
    preload(8'h10, 16'h1234);
    preload(8'h01, 16'h0C0C);
    preload(8'h20, 16'hAAAA);
    preload(8'h21, 16'h5555);
    test_reset();
    test_cpu_read();
    test_first_tie();
    test_round_robin();
    test_lock();
    test_back_to_back();
    test_reset_discard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
